// File: rtl/step_counter.sv
// Registered up/down counter with programmable step, parallel load and wrap/saturate mode.
// Carries a one-cycle wrap pulse, a sticky overflow flag and a combinational next-value preview.
module step_counter #(
    parameter int               WIDTH     = 16,
    parameter int               STEP_W    = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_dir,
    input  logic [0:STEP_W-1] i_step,
    input  logic              i_load,
    input  logic [0:WIDTH-1]  i_load_val,
    input  logic              i_clr_flag,
    output logic [0:WIDTH-1]  o_count,
    output logic [0:WIDTH-1]  o_next,
    output logic              o_wrap,
    output logic              o_ovf,
    output logic              o_zero
);

    logic [STEP_W-1:0] step_v;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  step_ext;
    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  next_val;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic              step_evt;
    logic              wrap_q;
    logic              ovf_q;

    // Port bit i carries weight 2^i, so map index-for-index onto descending internal vectors.
    for (genvar i = 0; i < STEP_W; i++) begin : g_step_map
        assign step_v[i] = i_step[i];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_val_map
        assign load_val[i] = i_load_val[i];
        assign o_count[i]  = count_q[i];
        assign o_next[i]   = next_val[i];
    end

    always_comb begin
        step_ext               = '0;
        step_ext[STEP_W-1:0]   = step_v;
        sum                    = {1'b0, count_q} + {1'b0, step_ext};
        diff                   = {1'b0, count_q} - {1'b0, step_ext};
        next_val               = count_q;
        step_evt               = 1'b0;
        if (i_load) begin
            next_val = load_val;
        end else if (i_en) begin
            if (i_dir) begin
                step_evt = sum[WIDTH];
                next_val = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end else begin
                // Top bit of the widened difference is the borrow.
                step_evt = diff[WIDTH];
                next_val = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= next_val;
            wrap_q  <= step_evt;
            if (step_evt) begin
                ovf_q <= 1'b1;
            end else if (i_clr_flag) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign o_wrap = wrap_q;
    assign o_ovf  = ovf_q;
    assign o_zero = (count_q == '0);

endmodule
